// File: rtl/clint_timer_pkg.sv
// Shared CLINT constants: base address, register offsets and offset decode.
package clint_timer_pkg;

  localparam logic [31:0] CLINT_BASE            = 32'h0200_0000;

  localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [15:0] ofs);
    clint_reg_e r;
    case (ofs)
      CLINT_MSIP_OFS:        r = REG_MSIP;
      CLINT_MTIMECMP_LO_OFS: r = REG_MTIMECMP_LO;
      CLINT_MTIMECMP_HI_OFS: r = REG_MTIMECMP_HI;
      CLINT_MTIME_LO_OFS:    r = REG_MTIME_LO;
      CLINT_MTIME_HI_OFS:    r = REG_MTIME_HI;
      default:               r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clint_timer_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset to 0.
module clint_timer_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip and synchronized external IRQ.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CLINT_BASE,
  parameter logic [15:0] TICK_DIV  = 16'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        ext_irq_async,
  output logic        timer_interrupt,
  output logic        software_interrupt,
  output logic        external_interrupt
);

  localparam logic [15:0] DIV_LAST = (TICK_DIV == 16'd0) ? 16'd0 : TICK_DIV - 16'd1;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] shadow_q, shadow_d;
  logic        prev_lo_q, prev_lo_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q;
  logic        timer_q;

  logic        sel;
  logic        wr;
  logic        rd;
  logic        tick;
  clint_reg_e  rsel;

  assign sel  = (bus_addr[31:16] == BASE_ADDR[31:16]) && (bus_wen || bus_ren);
  assign wr   = sel && bus_wen;
  assign rd   = sel && bus_ren;
  assign rsel = clint_decode(bus_addr[15:0]);
  assign tick = (presc_q == DIV_LAST);

  // A write to one mtime half replaces the tick result entirely: the other
  // half keeps its pre-tick value, so no carry leaks across on that cycle.
  always_comb begin
    mtime_d   = mtime_q + {63'd0, tick};
    presc_d   = tick ? '0 : presc_q + 16'd1;
    cmp_d     = cmp_q;
    msip_d    = msip_q;
    shadow_d  = shadow_q;
    prev_lo_d = prev_lo_q;

    if (wr) begin
      case (rsel)
        REG_MSIP:        msip_d = bus_wdata[0];
        REG_MTIMECMP_LO: cmp_d[31:0]  = bus_wdata;
        REG_MTIMECMP_HI: cmp_d[63:32] = bus_wdata;
        REG_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], bus_wdata};
          presc_d = '0;
        end
        REG_MTIME_HI: begin
          mtime_d = {bus_wdata, mtime_q[31:0]};
          presc_d = '0;
        end
        default: ;
      endcase
    end

    if (sel) begin
      prev_lo_d = rd && (rsel == REG_MTIME_LO);
    end
    if (rd && (rsel == REG_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  // Read mux samples pre-write state, so a combined wen/ren returns the old value.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (rsel)
        REG_MSIP:        rdata_d = {31'd0, msip_q};
        REG_MTIMECMP_LO: rdata_d = cmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = cmp_q[63:32];
        REG_MTIME_LO:    rdata_d = mtime_q[31:0];
        REG_MTIME_HI:    rdata_d = prev_lo_q ? shadow_q : mtime_q[63:32];
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q   <= '0;
      cmp_q     <= '1;
      presc_q   <= '0;
      shadow_q  <= '0;
      prev_lo_q <= 1'b0;
      msip_q    <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      prev_lo_q <= prev_lo_d;
      msip_q    <= msip_d;
      rdata_q   <= rdata_d;
      ready_q   <= sel;
      timer_q   <= (mtime_d >= cmp_d);
    end
  end

  clint_timer_sync2 u_ext_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (ext_irq_async),
    .q_o   (external_interrupt)
  );

  assign bus_rdata          = rdata_q;
  assign bus_ready          = ready_q;
  assign timer_interrupt    = timer_q;
  assign software_interrupt = msip_q;

endmodule
